// File: rtl/iir_biquad_mc.sv
// rtl/iir_biquad_mc.sv - multi-channel time-multiplexed Direct Form I biquad IIR filter
//
// Purpose:
//   Filters NUM_CH offset-binary sample channels per frame with one shared
//   signed multiplier. Each channel runs five multiply-accumulate cycles
//   (b0*x, b1*x1, b2*x2, a1*y1, a2*y2) and one write-back cycle. The
//   coefficients are shared by all channels, and each channel keeps its own
//   history registers.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   EN          block enable; dropping it mid-frame aborts the frame
//   START_FLAG  frame strobe, rising edge starts a frame
//   DATA_IN     packed offset-binary samples, channel k at [k*BITWIDTH +: BITWIDTH]
//   DATA_OUT    packed offset-binary results, same packing
//   DATA_VALID  one-cycle pulse when a complete frame of results is available
//   BUSY        high while a frame is being processed
//   OVR         sticky flag: a start edge arrived while busy
//   COEFF_WE    coefficient write strobe (ignored while busy)
//   COEFF_ADDR  0=b0 1=b1 2=b2 3=a1 4=a2, 5..7 ignored
//   COEFF_DATA  signed coefficient value, COEFF_FRAC fractional bits
//
// Build option:
//   IIR_BIQUAD_SATURATE_EN - when defined, the result is clamped to the signed
//   sample range. When undefined, the result wraps (truncated to BITWIDTH bits).

module iir_biquad_mc #(
  parameter int BITWIDTH    = 16,
  parameter int NUM_CH      = 4,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = 14
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         EN,
  input  logic                         START_FLAG,
  input  logic [NUM_CH*BITWIDTH-1:0]   DATA_IN,
  output logic [NUM_CH*BITWIDTH-1:0]   DATA_OUT,
  output logic                         DATA_VALID,
  output logic                         BUSY,
  output logic                         OVR,
  input  logic                         COEFF_WE,
  input  logic [2:0]                   COEFF_ADDR,
  input  logic [COEFF_WIDTH-1:0]       COEFF_DATA
);

  localparam int PW  = BITWIDTH + COEFF_WIDTH;
  localparam int AW  = PW + 3;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [BITWIDTH-1:0] MIDSCALE = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic signed [COEFF_WIDTH-1:0] B0_UNITY =
    {{(COEFF_WIDTH-COEFF_FRAC-1){1'b0}}, 1'b1, {COEFF_FRAC{1'b0}}};
  localparam logic signed [AW-1:0] RND = {{(AW-1){1'b0}}, 1'b1} << (COEFF_FRAC - 1);

  logic [2:0]                     state;
  logic                           start_q;
  logic [CHW-1:0]                 ch;
  logic [2:0]                     tap;
  logic [NUM_CH*BITWIDTH-1:0]     frame;
  logic [NUM_CH*BITWIDTH-1:0]     dout;
  logic                           ovr;
  logic signed [AW-1:0]           acc;

  logic signed [COEFF_WIDTH-1:0]  b0, b1, b2, a1, a2;
  logic signed [BITWIDTH-1:0]     x1 [NUM_CH];
  logic signed [BITWIDTH-1:0]     x2 [NUM_CH];
  logic signed [BITWIDTH-1:0]     y1 [NUM_CH];
  logic signed [BITWIDTH-1:0]     y2 [NUM_CH];

  logic                           start_edge;
  logic                           go_load;
  logic                           busy;
  logic [BITWIDTH-1:0]            x_raw;
  logic signed [BITWIDTH-1:0]     x_cur;
  logic signed [COEFF_WIDTH-1:0]  coef_sel;
  logic signed [BITWIDTH-1:0]     op_sel;
  logic                           sub;
  logic signed [PW-1:0]           coef_ext;
  logic signed [PW-1:0]           op_ext;
  logic signed [PW-1:0]           prod;
  logic signed [AW-1:0]           prod_ext;
  logic signed [AW-1:0]           acc_rnd;
  logic signed [AW-1:0]           acc_shift;
  logic signed [BITWIDTH-1:0]     y_new;

  assign start_edge = START_FLAG & ~start_q;
  assign go_load    = start_edge & EN & (state == S_IDLE);
  assign busy       = (state == S_LOAD) || (state == S_MAC) || (state == S_WB);

  // Offset-binary to two's complement: flip the MSB.
  assign x_raw = frame[ch*BITWIDTH +: BITWIDTH];
  assign x_cur = {~x_raw[BITWIDTH-1], x_raw[BITWIDTH-2:0]};

  always_comb begin
    coef_sel = b0;
    op_sel   = x_cur;
    sub      = 1'b0;
    case (tap)
      3'd1: begin coef_sel = b1; op_sel = x1[ch]; end
      3'd2: begin coef_sel = b2; op_sel = x2[ch]; end
      3'd3: begin coef_sel = a1; op_sel = y1[ch]; sub = 1'b1; end
      3'd4: begin coef_sel = a2; op_sel = y2[ch]; sub = 1'b1; end
      default: begin end
    endcase
  end

  assign coef_ext = {{BITWIDTH{coef_sel[COEFF_WIDTH-1]}}, coef_sel};
  assign op_ext   = {{COEFF_WIDTH{op_sel[BITWIDTH-1]}}, op_sel};
  assign prod     = coef_ext * op_ext;
  assign prod_ext = {{3{prod[PW-1]}}, prod};

  // Round half up, then drop the fractional bits.
  assign acc_rnd   = acc + RND;
  assign acc_shift = acc_rnd >>> COEFF_FRAC;

`ifdef IIR_BIQUAD_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

  always_comb begin
    y_new = acc_shift[BITWIDTH-1:0];
    if (acc_shift > SAT_MAX)
      y_new = SAT_MAX[BITWIDTH-1:0];
    else if (acc_shift < SAT_MIN)
      y_new = SAT_MIN[BITWIDTH-1:0];
  end
`else
  // Two's-complement wrap: the upper bits are simply discarded.
  logic unused_hi;
  assign y_new     = acc_shift[BITWIDTH-1:0];
  assign unused_hi = ^acc_shift[AW-1:BITWIDTH];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      ch      <= '0;
      tap     <= '0;
      acc     <= '0;
      frame   <= '0;
      dout    <= {NUM_CH{MIDSCALE}};
      ovr     <= 1'b0;
      b0      <= B0_UNITY;
      b1      <= '0;
      b2      <= '0;
      a1      <= '0;
      a2      <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        x1[k] <= '0;
        x2[k] <= '0;
        y1[k] <= '0;
        y2[k] <= '0;
      end
    end else begin
      start_q <= START_FLAG;

      if (start_edge && busy)
        ovr <= 1'b1;

      // Coefficients stay frozen from the accepting edge to the end of the frame.
      if (COEFF_WE && !busy && !go_load) begin
        case (COEFF_ADDR)
          3'd0: b0 <= $signed(COEFF_DATA);
          3'd1: b1 <= $signed(COEFF_DATA);
          3'd2: b2 <= $signed(COEFF_DATA);
          3'd3: a1 <= $signed(COEFF_DATA);
          3'd4: a2 <= $signed(COEFF_DATA);
          default: begin end
        endcase
      end

      if (!EN && busy) begin
        // Abort: channels already written back keep their new history.
        state <= S_IDLE;
        tap   <= '0;
        acc   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (go_load)
              state <= S_LOAD;
          end
          S_LOAD: begin
            frame <= DATA_IN;
            ch    <= '0;
            tap   <= '0;
            acc   <= '0;
            state <= S_MAC;
          end
          S_MAC: begin
            acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
            if (tap == 3'd4) begin
              tap   <= '0;
              state <= S_WB;
            end else begin
              tap <= tap + 3'd1;
            end
          end
          S_WB: begin
            x2[ch] <= x1[ch];
            x1[ch] <= x_cur;
            y2[ch] <= y1[ch];
            y1[ch] <= y_new;
            dout[ch*BITWIDTH +: BITWIDTH] <= {~y_new[BITWIDTH-1], y_new[BITWIDTH-2:0]};
            acc <= '0;
            if (ch == LAST_CH) begin
              state <= S_DONE;
            end else begin
              ch    <= ch + CHW'(1);
              state <= S_MAC;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign DATA_OUT   = dout;
  assign DATA_VALID = (state == S_DONE);
  assign BUSY       = busy;
  assign OVR        = ovr;

endmodule
